// File: rtl/riscv_fetch_stage_if.sv
// riscv_fetch_stage_if: instruction memory, redirect and decode-side handshake bundle
interface riscv_fetch_stage_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC owner, word fetcher and prefetch FIFO feeding decode
module riscv_fetch_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    riscv_fetch_stage_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic            kill;
    logic            valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occ;
    logic            unused_bits;
    assign unused_bits = ^bus.redirect_pc[1:0];
    // occ counts buffered plus returning words, net of this cycle's pop
    always_comb begin
        valid = count != '0;
        pop   = valid && bus.inst_ready;
        push  = inflight && !kill;
        occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        issue = !rst && !bus.redirect_valid && occ < (CW+1)'(FIFO_DEPTH);
    end
    assign bus.imem_req   = issue;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = valid;
    assign bus.inst_data  = valid ? fifo_data[rd_ptr] : '0;
    assign bus.inst_pc    = valid ? fifo_pc[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            kill     <= inflight;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= 1'b0;
            if (issue) begin
                pc     <= pc + XLEN'(4);
                req_pc <= pc;
            end
            if (push) begin
                fifo_data[wr_ptr] <= bus.imem_rdata;
                fifo_pc[wr_ptr]   <= req_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: randomized and directed checks against an in-order fetch stream model
module tb_riscv_fetch_stage;
    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] SUB = 32'h402081B3;
    localparam logic [31:0] XOR = 32'h0020C1B3;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic redir = 1'b0;
    logic [31:0] redir_pc = '0;
    int checks = 0;
    int errors = 0;
    riscv_fetch_stage_if #(.XLEN(32)) f0 ();
    riscv_fetch_stage_if #(.XLEN(32)) f1 ();
    assign f0.inst_ready = ready;
    assign f0.redirect_valid = redir;
    assign f0.redirect_pc = redir_pc;
    assign f1.inst_ready = ready;
    assign f1.redirect_valid = redir;
    assign f1.redirect_pc = redir_pc;
    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2))
        dut0 (.clk(clk), .rst(rst), .bus(f0.master));
    riscv_fetch_stage #(.XLEN(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(2))
        dut1 (.clk(clk), .rst(rst), .bus(f1.master));
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? ADD : a == 32'h4 ? SUB : a == 32'h8 ? XOR : (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    always @(posedge clk) begin
        f0.imem_rdata <= mem_word(f0.imem_addr);
        f1.imem_rdata <= mem_word(f1.imem_addr);
    end

    // Stream model: every accepted instruction must be the next sequential word since the last reset/redirect
    int occ = 0;
    logic [31:0] exp_pc = '0;
    logic req_prev = 1'b0;
    logic pop_m, exp_req;
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            exp_pc = 32'h0;
        end else begin
            pop_m = f0.inst_valid && ready;
            checks++;
            if (f0.inst_valid !== (occ != 0)) begin
                errors++;
                $display("FAIL mon_valid t=%0t: got %b expected %b", $time, f0.inst_valid, occ != 0);
            end
            checks++;
            if (occ > 2) begin
                errors++;
                $display("FAIL mon_overflow t=%0t: buffered %0d exceeds 2", $time, occ);
            end
            exp_req = !redir && (occ + int'(req_prev) - int'(pop_m)) < 2;
            checks++;
            if (f0.imem_req !== exp_req) begin
                errors++;
                $display("FAIL mon_req t=%0t: got %b expected %b", $time, f0.imem_req, exp_req);
            end
            if (pop_m) begin
                checks++;
                if (f0.inst_pc !== exp_pc || f0.inst_data !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL mon_stream t=%0t: got pc %h data %h expected pc %h data %h",
                             $time, f0.inst_pc, f0.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                exp_pc = {redir_pc[31:2], 2'b00};
                occ = 0;
            end else occ = occ + int'(req_prev) - int'(pop_m);
        end
        req_prev = f0.imem_req;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redir = 1'b0;
        ready = rdy;
        repeat (3) go();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redir = 1'b0;
        ready = 1'b1;
        repeat (3) begin
            look();
            checks++;
            if (f0.imem_req !== 1'b0 || f0.inst_valid !== 1'b0 || f0.imem_addr !== 32'h0 ||
                f0.inst_data !== 32'h0 || f0.inst_pc !== 32'h0 || f1.imem_addr !== WRAP_PC) begin
                errors++;
                $display("FAIL reset_outputs: got req %b valid %b addr %h data %h pc %h addr1 %h expected 0 0 0 0 0 %h",
                         f0.imem_req, f0.inst_valid, f0.imem_addr, f0.inst_data, f0.inst_pc, f1.imem_addr, WRAP_PC);
            end
            go();
        end
        rst = 1'b0;
    endtask

    task automatic test_startup_stream();
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] dat [3] = '{ADD, SUB, XOR};
        look();
        checks++;
        if (f0.imem_req !== 1'b1 || f0.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h expected 1 00000000", f0.imem_req, f0.imem_addr);
        end
        go();
        look();
        checks++;
        if (f0.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got %b expected 0", f0.inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            go();
            look();
            checks++;
            if (f0.inst_valid !== 1'b1 || f0.inst_pc !== pcs[i] || f0.inst_data !== dat[i]) begin
                errors++;
                $display("FAIL stream_%0d: got valid %b pc %h data %h expected 1 %h %h",
                         i, f0.inst_valid, f0.inst_pc, f0.inst_data, pcs[i], dat[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            go();
            look();
            checks++;
            if (f0.inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL throughput_%0d: got valid %b expected 1", i, f0.inst_valid);
            end
        end
        go();
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset(1'b1);
        look();
        checks++;
        if (f1.imem_addr !== WRAP_PC || f1.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first_req: got req %b addr %h expected 1 %h", f1.imem_req, f1.imem_addr, WRAP_PC);
        end
        go();
        for (int i = 0; i < 3; i++) begin
            go();
            look();
            checks++;
            if (f1.inst_valid !== 1'b1 || f1.inst_pc !== pcs[i] || f1.inst_data !== mem_word(pcs[i])) begin
                errors++;
                $display("FAIL wrap_%0d: got valid %b pc %h data %h expected 1 %h %h",
                         i, f1.inst_valid, f1.inst_pc, f1.inst_data, pcs[i], mem_word(pcs[i]));
            end
        end
        go();
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        do_reset(1'b0);
        repeat (8) begin
            look();
            if (f0.imem_req) n++;
            go();
        end
        look();
        checks++;
        if (n != 2 || f0.imem_req !== 1'b0 || f0.inst_valid !== 1'b1 || f0.inst_pc !== 32'h0 || f0.inst_data !== ADD) begin
            errors++;
            $display("FAIL bp_hold: got reqs %0d req %b valid %b pc %h data %h expected 2 0 1 00000000 %h",
                     n, f0.imem_req, f0.inst_valid, f0.inst_pc, f0.inst_data, ADD);
        end
        go();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            checks++;
            if (f0.inst_valid !== 1'b1 || f0.inst_pc !== pcs[i]) begin
                errors++;
                $display("FAIL bp_drain_%0d: got valid %b pc %h expected 1 %h", i, f0.inst_valid, f0.inst_pc, pcs[i]);
            end
            go();
        end
    endtask

    task automatic redirect_and_check(input logic [31:0] tgt, input string name);
        logic [31:0] al;
        al = {tgt[31:2], 2'b00};
        redir = 1'b1;
        redir_pc = tgt;
        go();
        redir = 1'b0;
        look();
        checks++;
        if (f0.imem_req !== 1'b1 || f0.imem_addr !== al || f0.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_req: got req %b addr %h valid %b expected 1 %h 0", name, f0.imem_req, f0.imem_addr, f0.inst_valid, al);
        end
        go();
        look();
        checks++;
        if (f0.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap: got valid %b expected 0", name, f0.inst_valid);
        end
        go();
        look();
        checks++;
        if (f0.inst_valid !== 1'b1 || f0.inst_pc !== al || f0.inst_data !== mem_word(al)) begin
            errors++;
            $display("FAIL %s_target: got valid %b pc %h data %h expected 1 %h %h",
                     name, f0.inst_valid, f0.inst_pc, f0.inst_data, al, mem_word(al));
        end
        go();
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        repeat (3) go();
        redirect_and_check(32'h20, "redir");
        repeat (6) begin
            look();
            checks++;
            if (f0.inst_valid && f0.inst_pc == 32'h8) begin
                errors++;
                $display("FAIL redir_stale: got pc %h expected anything but 00000008", f0.inst_pc);
            end
            go();
        end
        redirect_and_check(32'h22, "misalign");
        go();
        redir = 1'b1;
        redir_pc = 32'h100;
        go();
        redirect_and_check(32'h206, "b2b");
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (6) go();
        ready = 1'b1;
        go();
        ready = 1'b0;
        rst = 1'b1;
        look();
        checks++;
        if (f0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_req: got %b expected 0", f0.imem_req);
        end
        go();
        look();
        checks++;
        if (f0.inst_valid !== 1'b0 || f0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got valid %b req %b expected 0 0", f0.inst_valid, f0.imem_req);
        end
        go();
        rst = 1'b0;
        ready = 1'b1;
        look();
        checks++;
        if (f0.imem_req !== 1'b1 || f0.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_restart: got req %b addr %h expected 1 00000000", f0.imem_req, f0.imem_addr);
        end
        go();
        go();
        look();
        checks++;
        if (f0.inst_valid !== 1'b1 || f0.inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_first: got valid %b pc %h expected 1 00000000", f0.inst_valid, f0.inst_pc);
        end
        go();
    endtask

    task automatic test_random();
        int pops = 0;
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) begin
            ready = $urandom_range(0, 3) != 0;
            redir = $urandom_range(0, 15) == 0;
            redir_pc = $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            look();
            if (f0.inst_valid && ready) pops++;
            go();
        end
        redir = 1'b0;
        ready = 1'b1;
        checks++;
        if (pops < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d deliveries expected at least 100", pops);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_startup_stream();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_stage.md
# riscv_fetch_stage

Instruction fetch stage for the RV32I core: owns the program counter, issues word reads to the byte-addressed instruction memory, and buffers returned instructions in a small prefetch FIFO. It delivers `{pc, instruction}` pairs to the decode/register-file stage over a valid/ready handshake. It accepts redirects (taken branch, jal/jalr) from the execute stage, which flush buffered and in-flight fetches.

## Interface
Parameters:
- `XLEN`, 32, data and address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; low two bits must be 0
- `FIFO_DEPTH`, 2, prefetch entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  XLEN  byte address of the requested word; always a multiple of 4
- `imem_rdata`  in  XLEN  instruction word; valid exactly one cycle after `imem_req`
- `redirect_valid`  in  1  execute stage requests a PC change
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- `inst_valid`  out  1  FIFO head holds a valid instruction
- `inst_ready`  in  1  downstream accepts the head this cycle
- `inst_data`  out  XLEN  instruction at FIFO head
- `inst_pc`  out  XLEN  byte address of `inst_data`

## Operation
- State: `pc` (next fetch address), FIFO of `{pc, data}` entries, `count` (0..FIFO_DEPTH), `inflight` (0/1), `kill` (0/1).
- Issue: `imem_req=1` and `imem_addr=pc` when `!rst && !redirect_valid && (count + inflight − pop) < FIFO_DEPTH`, where `pop = inst_valid && inst_ready`. On issue, `pc ← pc + 4` (mod 2^XLEN, wraps 0xFFFF_FFFC→0) and `inflight ← 1`; otherwise `inflight ← 0`.
- Response: in the cycle after an issue, `imem_rdata` is pushed together with its issue address, unless `kill=1`, in which case it is discarded.
- Output: `inst_valid = (count != 0)`; `inst_data`/`inst_pc` show the head entry and are held stable while `inst_valid && !inst_ready`.
- Simultaneous push and pop are allowed at any count, including full; `count` is unchanged.
- Redirect (highest priority over issue, push, and pop): `pc ← {redirect_pc[XLEN-1:2], 2'b00}`, FIFO emptied (`count ← 0`), `kill ← inflight`, and no request that cycle. A pop in the redirect cycle is still a valid handshake from the consumer's side, but the entry is discarded by the flush.
- `kill` clears after one cycle. Back-to-back redirects are legal; the last one wins.
- Overflow is impossible by construction. If a push occurs with `count == FIFO_DEPTH` and no pop, it is a design error; the bench asserts against it.

## Timing
- Reset (cycle in which `rst=1`): `pc=RESET_PC`, `count=0`, `inflight=0`, `kill=0`. Outputs are `imem_req=0`, `inst_valid=0`, `imem_addr=RESET_PC`, `inst_data=0`, `inst_pc=0`.
- Reset asserted mid-operation takes effect at the next edge; all buffered and in-flight data is lost.
- First request is issued in the first cycle with `rst=0` (cycle C).
- Data returns in C+1 and is written into the FIFO at the end of C+1. `inst_valid=1` from C+2.
- Fetch-to-valid latency is 2 cycles.
- With `inst_ready=1` held, throughput is one instruction per cycle.
- Redirect in cycle R: request to the new target is issued in R+1, and the first instruction from the target is valid in R+3. No instruction fetched before the redirect appears at or after R+1.
- Backpressure: with `inst_ready=0`, at most FIFO_DEPTH words are buffered, and `imem_req` deasserts combinationally once the FIFO plus in-flight count is full.

## Test plan
- Reset / startup: assert `rst` for 3 cycles → `imem_req=0` and `inst_valid=0` during reset. First request at 0x0 in cycle C; `inst_valid` in C+2 with `inst_pc=0x0`.
- Streaming: memory holds add/sub/xor at 0x0/0x4/0x8, `inst_ready=1` → consecutive cycles deliver `inst_pc` 0x0, 0x4, 0x8 with `inst_data` 0x002081B3 (add), 0x402081B3 (sub), 0x0020C1B3 (xor).
- Backpressure: `inst_ready=0` from start → exactly 2 words buffered, then `imem_req=0`. Release `inst_ready` → delivery in order 0x0, 0x4, 0x8 with none dropped or duplicated.
- Redirect mid-stream: `redirect_valid=1`, `redirect_pc=0x20` while 0x8 is in flight → 0x8 and any buffered entries never appear. The next `inst_pc` is 0x20, valid 3 cycles after the redirect.
- Misaligned and wrap cases:
  - `redirect_pc=0x22` → fetch resumes at 0x20.
  - `RESET_PC=0xFFFF_FFF8` → `inst_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Reset mid-operation: assert `rst` with a full FIFO and a request in flight → the next cycle has `inst_valid=0` and `imem_req=0`. After release, fetch restarts at `RESET_PC`.
